// File: rtl/mux4_stream_serializer_pkg.sv
// mux4_stream_serializer_pkg: shared state encoding, lane geometry and lane-order helpers
package mux4_stream_serializer_pkg;

    typedef enum logic {IDLE, SHIFT} state_e;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] LSB_START = 2'd0;
    localparam logic [SEL_W-1:0] LSB_END   = 2'd3;
    localparam logic [SEL_W-1:0] MSB_START = 2'd3;
    localparam logic [SEL_W-1:0] MSB_END   = 2'd0;

    function automatic logic [SEL_W-1:0] start_lane(input bit msb_first);
        return msb_first ? MSB_START : LSB_START;
    endfunction

    function automatic logic [SEL_W-1:0] end_lane(input bit msb_first);
        return msb_first ? MSB_END : LSB_END;
    endfunction

endpackage

// File: rtl/mux4_stream_serializer_if.sv
// mux4_stream_serializer_if: parallel-word input and serial-beat output handshake bundle
interface mux4_stream_serializer_if
    import mux4_stream_serializer_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic [LANES-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_first;
    logic             ser_last;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic [CNT_W-1:0] words_sent;

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, sel, busy, words_sent
    );

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, sel, busy, words_sent
    );

endinterface

// File: rtl/mux4_stream_serializer_mux4x1.sv
// mux4_stream_serializer_mux4x1: 4:1 lane mux (MUX_4x1) picking the serial bit
module mux4_stream_serializer_mux4x1
    import mux4_stream_serializer_pkg::*;
(
    input  logic [LANES-1:0] in_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             out_o
);

    always_comb out_o = in_i[sel_i];

endmodule

// File: rtl/mux4_stream_serializer.sv
// mux4_stream_serializer: serialises 4-bit words one lane per beat with a one-word shadow buffer
module mux4_stream_serializer
    import mux4_stream_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input logic                    clk,
    input logic                    rst,
    mux4_stream_serializer_if.slave bus
);

    localparam logic [SEL_W-1:0] START = start_lane(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST  = end_lane(MSB_FIRST);

    state_e           state_q, state_d;
    logic [LANES-1:0] active_q, active_d;
    logic [LANES-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer, beat, last_beat, ser_bit;

    assign bus.in_ready   = ~rst & ~shadow_full_q;
    assign bus.ser_valid  = state_q == SHIFT;
    assign bus.busy       = state_q == SHIFT;
    assign bus.ser_first  = bus.ser_valid & (sel_q == START);
    assign bus.ser_last   = bus.ser_valid & (sel_q == LAST);
    assign bus.sel        = sel_q;
    assign bus.words_sent = cnt_q;
    assign bus.ser_out    = ser_bit;

    assign in_xfer   = bus.in_valid & bus.in_ready;
    assign beat      = bus.ser_valid & bus.ser_ready;
    assign last_beat = beat & (sel_q == LAST);

    mux4_stream_serializer_mux4x1 u_mux_4x1 (
        .in_i  (active_q),
        .sel_i (sel_q),
        .out_o (ser_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            sel_q         <= START;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
        end
    end

    // On the last beat the next word comes from shadow first, else straight from the input
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        if (state_q == IDLE) begin
            if (in_xfer) begin
                active_d = bus.in_data;
                sel_d    = START;
                state_d  = SHIFT;
            end
        end else begin
            if (in_xfer && !last_beat) begin
                shadow_d      = bus.in_data;
                shadow_full_d = 1'b1;
            end
            if (beat)
                sel_d = MSB_FIRST ? sel_q - 2'd1 : sel_q + 2'd1;
            if (last_beat) begin
                cnt_d = cnt_q + CNT_W'(1);
                sel_d = START;
                if (shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_d      = '0;
                    shadow_full_d = 1'b0;
                end else if (in_xfer) begin
                    active_d = bus.in_data;
                end else begin
                    active_d = '0;
                    state_d  = IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux4_stream_serializer.sv
// tb_mux4_stream_serializer: scoreboard bench driving LSB-first and MSB-first instances in lockstep
module tb_mux4_stream_serializer;
    import mux4_stream_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux4_stream_serializer_if #(.CNT_W(8)) bus0 ();
    mux4_stream_serializer_if #(.CNT_W(8)) bus1 ();

    mux4_stream_serializer #(.MSB_FIRST(1'b0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mux4_stream_serializer #(.MSB_FIRST(1'b1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [7:0] exp_w0 = '0;
    logic [7:0] exp_w1 = '0;
    int vcnt, bubble, ready_low;
    bit xfer;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] d, input bit sr);
        bus0.in_valid = v; bus0.in_data = d; bus0.ser_ready = sr;
        bus1.in_valid = v; bus1.in_data = d; bus1.ser_ready = sr;
    endtask

    // Expected beat entry: {sel, first, last, bit}
    task automatic tick();
        logic [4:0] e;
        logic [1:0] l;
        #1;
        xfer = 1'b0;
        if (!rst) begin
            if (bus0.ser_valid) vcnt++;
            else if (vcnt > 0 && q0.size() > 0) bubble++;
            if (!bus0.in_ready) ready_low++;
            if (!bus0.ser_valid) check("gate0", {bus0.ser_first, bus0.ser_last}, 0);
            if (!bus1.ser_valid) check("gate1", {bus1.ser_first, bus1.ser_last}, 0);
            if (bus0.ser_valid && bus0.ser_ready) begin
                if (q0.size() == 0) check("extra0", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("beat0", {bus0.sel, bus0.ser_first, bus0.ser_last, bus0.ser_out}, e);
                    if (e[1]) exp_w0++;
                end
            end
            if (bus1.ser_valid && bus1.ser_ready) begin
                if (q1.size() == 0) check("extra1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("beat1", {bus1.sel, bus1.ser_first, bus1.ser_last, bus1.ser_out}, e);
                    if (e[1]) exp_w1++;
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                xfer = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    l = 2'(k);
                    q0.push_back({l, k == 0, k == 3, bus0.in_data[l]});
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                for (int k = 0; k < 4; k++) begin
                    l = 2'(3 - k);
                    q1.push_back({l, k == 0, k == 3, bus1.in_data[l]});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, 4'h0, 1'b1);
        while ((q0.size() != 0 || q1.size() != 0 || bus0.ser_valid || bus1.ser_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 200, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] w3 [3];
        logic [7:0] snap;
        logic [3:0] d;
        int i, n;
        w3[0] = 4'hF; w3[1] = 4'h0; w3[2] = 4'h9;

        drive(1'b1, 4'h5, 1'b1);
        @(negedge clk);
        tick();
        tick();
        check("rst_in_ready", bus0.in_ready, 0);
        check("rst_ser_valid", bus0.ser_valid, 0);
        check("rst_words", bus0.words_sent, 0);
        check("rst_sel0", bus0.sel, 0);
        check("rst_sel1", bus1.sel, 3);
        check("rst_busy", bus0.busy, 0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b1);
        tick();
        check("idle_in_ready", bus0.in_ready, 1);

        drive(1'b1, 4'b1010, 1'b1);
        tick();
        check("xfer_a", xfer, 1);
        drive(1'b0, 4'h0, 1'b1);
        check("latency", bus0.ser_valid, 1);
        check("start_sel0", bus0.sel, 0);
        check("start_sel1", bus1.sel, 3);
        drain();
        check("words_a0", bus0.words_sent, 1);
        check("words_a1", bus1.words_sent, exp_w1);
        check("idle_a", bus0.busy, 0);

        vcnt = 0; bubble = 0; ready_low = 0;
        i = 0; n = 0;
        while (i < 3 && n < 50) begin
            drive(1'b1, w3[i], 1'b1);
            tick();
            if (xfer) i++;
            n++;
        end
        check("b2b_feed", i, 3);
        drain();
        check("b2b_beats", vcnt, 12);
        check("b2b_bubble", bubble, 0);
        check("b2b_ready_low", ready_low > 0, 1);
        check("words_b0", bus0.words_sent, 4);
        check("words_b1", bus1.words_sent, exp_w1);

        drive(1'b1, 4'b0110, 1'b1);
        tick();
        check("xfer_c", xfer, 1);
        drive(1'b0, 4'h0, 1'b1);
        tick();
        tick();
        drive(1'b0, 4'h0, 1'b0);
        snap = {bus0.sel, bus0.ser_out, bus0.ser_valid, bus1.sel, bus1.ser_out, bus1.ser_valid};
        check("bp_sel", bus0.sel, 2);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold", {bus0.sel, bus0.ser_out, bus0.ser_valid, bus1.sel, bus1.ser_out, bus1.ser_valid}, snap);
        end
        drain();
        check("words_c0", bus0.words_sent, exp_w0);

        drive(1'b1, 4'hC, 1'b1);
        tick();
        drive(1'b1, 4'h3, 1'b1);
        tick();
        check("xfer_shadow", xfer, 1);
        drive(1'b0, 4'h0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        q0.delete(); q1.delete();
        exp_w0 = '0; exp_w1 = '0;
        check("mid_rst_valid", bus0.ser_valid, 0);
        check("mid_rst_ready", bus0.in_ready, 0);
        check("mid_rst_words", bus0.words_sent, 0);
        rst = 1'b0;
        tick();
        check("post_rst_valid0", bus0.ser_valid, 0);
        check("post_rst_valid1", bus1.ser_valid, 0);
        check("post_rst_ready", bus0.in_ready, 1);
        tick();
        tick();
        check("shadow_drop", {bus0.ser_valid, bus1.ser_valid}, 0);

        i = 0; n = 0;
        d = 4'($urandom);
        while (i < 256 && n < 5000) begin
            drive(1'b1, d, $urandom_range(0, 3) != 0);
            tick();
            if (xfer) begin
                i++;
                d = 4'($urandom);
            end
            n++;
        end
        check("wrap_feed", i, 256);
        drain();
        check("wrap0", bus0.words_sent, 0);
        check("wrap1", bus1.words_sent, 0);
        check("wrap_model", bus0.words_sent, exp_w0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
